// File: rtl/dsp_acc_drain.sv
// ---------------------------------------------------------------------------
// dsp_acc_drain
//   Drain stage behind dsp_group. dsp_group produces a signed 16-bit partial
//   sum (res) LAT cycles after a beat is presented to it, but it carries no
//   valid or stall. This block runs the beat tags through a matching LAT-deep
//   delay line, accumulates res over each group of beats, and saturates the
//   group sum to 16 bits. Each result is queued in a small first-word-fall-
//   through FIFO with a valid/ready output. The feeder gets a credit
//   (issue_ok) so that it only closes a group when a FIFO slot is reserved.
//
// Ports
//   clk, rstn   clock; synchronous active-low reset
//   clr         soft flush of delay line, accumulator and FIFO (stickies kept)
//   beat_valid  a beat enters dsp_group this cycle
//   beat_last   that beat closes the current group
//   res         dsp_group partial sum, signed, aligned LAT cycles after beat
//   issue_ok    a group may be closed this cycle
//   out_valid / out_ready / out_data / out_sat / out_cnt
//               FIFO head: saturated sum, clip flag, beats in group
//   acc_ovf     sticky: accumulator wrapped (signed overflow)
//   drop_err    sticky: a group closed with the FIFO full; result discarded
//   busy        beats still in flight or a group partially accumulated
// ---------------------------------------------------------------------------
module dsp_acc_drain #(
    parameter int LAT        = 7,
    parameter int ACC_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    beat_valid,
    input  logic                    beat_last,
    input  logic signed [15:0]      res,
    output logic                    issue_ok,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [15:0]      out_data,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    acc_ovf,
    output logic                    drop_err,
    output logic                    busy
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int LCNT_W = $clog2(LAT + 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) return 16'h7FFF;
        if (v < SAT_LO) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic clip16(input logic signed [ACC_W-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    // Two same-signed operands giving a result of the other sign means wrap.
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b,
                                     input logic signed [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    // ---- tag delay line: bit LAT-1 lines up with res this cycle ----
    logic [LAT-1:0] vld_dl;
    logic [LAT-1:0] lst_dl;
    logic           vld_p0;
    logic           lst_p0;
    logic           run_q;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            vld_dl <= '0;
            lst_dl <= '0;
        end else begin
            vld_dl <= {vld_dl[LAT-2:0], beat_valid};
            lst_dl <= {lst_dl[LAT-2:0], beat_valid & beat_last};
        end
    end

    assign vld_p0 = vld_dl[LAT-1];
    assign lst_p0 = lst_dl[LAT-1];

    // Holds issue_ok low while reset or clr is applied.
    always_ff @(posedge clk) begin
        if (!rstn) run_q <= 1'b0;
        else       run_q <= ~clr;
    end

    // ---- p0: accumulate aligned res ----
    logic signed [ACC_W-1:0] acc_p0;
    logic signed [ACC_W-1:0] res_ext_p0;
    logic signed [ACC_W-1:0] sum_p0;
    logic [CNT_W-1:0]        cnt_p0;
    logic [CNT_W-1:0]        cnt_nxt_p0;

    assign res_ext_p0 = {{(ACC_W-16){res[15]}}, res};
    assign sum_p0     = acc_p0 + res_ext_p0;
    assign cnt_nxt_p0 = cnt_p0 + CNT_W'(1);

    // Closing beat clears acc/cnt on the same edge it pushes, so the next
    // group can start in the very next cycle.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (vld_p0) begin
            if (lst_p0) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else begin
                acc_p0 <= sum_p0;
                cnt_p0 <= cnt_nxt_p0;
            end
        end
    end

    // ---- p1: result FIFO ----
    logic signed [15:0] mem_data [FIFO_DEPTH];
    logic               mem_sat  [FIFO_DEPTH];
    logic [CNT_W-1:0]   mem_cnt  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   fifo_cnt;
    logic               full;
    logic               pop;
    logic               push_p0;
    logic               wr_en;
    logic               drop_p0;

    assign full      = (fifo_cnt == OCC_W'(FIFO_DEPTH));
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid & out_ready;
    assign push_p0   = vld_p0 & lst_p0;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en     = push_p0 & (~full | pop);
    assign drop_p0   = push_p0 & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= sat16(sum_p0);
            mem_sat[wr_ptr]  <= clip16(sum_p0);
            mem_cnt[wr_ptr]  <= cnt_nxt_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + OCC_W'(wr_en) - OCC_W'(pop);
        end
    end

    // Storage is not reset; the head is masked so an empty FIFO reads as 0.
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_sat  = out_valid ? mem_sat[rd_ptr]  : 1'b0;
    assign out_cnt  = out_valid ? mem_cnt[rd_ptr]  : '0;

    // ---- sticky error flags (only reset clears them) ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_ovf  <= 1'b0;
            drop_err <= 1'b0;
        end else if (!clr) begin
            if (vld_p0 && add_ovf(acc_p0, res_ext_p0, sum_p0)) acc_ovf <= 1'b1;
            if (drop_p0) drop_err <= 1'b1;
        end
    end

    // ---- credit: slots not yet claimed by queued or in-flight groups ----
    logic [LCNT_W-1:0] lst_inflight;

    always_comb begin
        lst_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            lst_inflight = lst_inflight + LCNT_W'(lst_dl[i]);
        end
    end

    assign issue_ok = run_q && ((32'(fifo_cnt) + 32'(lst_inflight)) < 32'(FIFO_DEPTH));
    assign busy     = (|vld_dl) | (cnt_p0 != '0);

endmodule

// File: tb/tb_dsp_acc_drain.sv
// ---------------------------------------------------------------------------
// tb_dsp_acc_drain
//   Bench for dsp_acc_drain. A small dsp_group stand-in delays each beat's
//   res value by LAT cycles. The reference model sums each group with plain
//   integer arithmetic and pushes the expected saturated result into a
//   queue when the closing beat is issued. A separate monitor pops the queue
//   whenever the DUT hands over a result.
// ---------------------------------------------------------------------------
module tb_dsp_acc_drain;
    localparam int LAT   = 7;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   clr;
    logic                   beat_valid;
    logic                   beat_last;
    logic signed [15:0]     beat_res;
    logic signed [15:0]     res;
    logic                   issue_ok;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [15:0]     out_data;
    logic                   out_sat;
    logic [CNT_W-1:0]       out_cnt;
    logic                   acc_ovf;
    logic                   drop_err;
    logic                   busy;

    logic signed [15:0]     res_pipe [LAT];

    typedef struct {
        longint data;
        longint sat;
        longint cnt;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_checks   = 0;
    int     n_fail     = 0;
    longint grp_sum    = 0;
    int     grp_cnt    = 0;
    int     ready_mode = 0;
    int     glen;
    int     spin;

    always #5 clk = ~clk;

    dsp_acc_drain #(.LAT(LAT), .ACC_W(32), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .res        (res),
        .issue_ok   (issue_ok),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_cnt    (out_cnt),
        .acc_ovf    (acc_ovf),
        .drop_err   (drop_err),
        .busy       (busy)
    );

    // dsp_group stand-in: res for a beat appears LAT cycles later.
    always @(posedge clk) begin
        res_pipe[0] <= beat_res;
        for (int i = 1; i < LAT; i++) res_pipe[i] <= res_pipe[i-1];
    end
    assign res = res_pipe[LAT-1];

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: exact group sum clipped to the signed 16-bit range.
    function automatic exp_t mk_exp(input longint s, input int c);
        exp_t e;
        if (s > 32767) begin
            e.data = 32767;  e.sat = 1;
        end else if (s < -32768) begin
            e.data = -32768; e.sat = 1;
        end else begin
            e.data = s;      e.sat = 0;
        end
        e.cnt = c % 65536;
        return e;
    endfunction

    function automatic logic signed [15:0] rnd_res();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return 16'($urandom);
        return 16'(int'($urandom_range(0, 400)) - 200);
    endfunction

    // Present one cycle of feeder inputs; returns 1 time unit after the edge.
    task automatic drive(input bit v, input bit l, input logic signed [15:0] r,
                         input bit expect_drop);
        beat_valid = v;
        beat_last  = l;
        beat_res   = r;
        if (v) begin
            grp_sum += r;
            grp_cnt++;
            if (l) begin
                if (!expect_drop) exp_q.push_back(mk_exp(grp_sum, grp_cnt));
                grp_sum = 0;
                grp_cnt = 0;
            end
        end
        @(posedge clk); #1;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_res   = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic model_flush();
        exp_q.delete();
        grp_sum = 0;
        grp_cnt = 0;
    endtask

    // Consumer: 0 hold, 1 accept, 2 toggle, 3 random. Applied at edge+2 so
    // the main sequence can change the mode at edge+1 for the same cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom);
            endcase
        end
    end

    // Monitor: every accepted head must match the oldest expected result.
    always @(negedge clk) begin
        if (rstn && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got data %0d cnt %0d, none expected",
                         out_data, out_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_sat",  out_sat,  mon_e.sat);
                check("out_cnt",  out_cnt,  mon_e.cnt);
            end
        end
    end

    initial begin
        rstn       = 1'b0;
        clr        = 1'b0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_res   = '0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_issue_ok",  issue_ok,  0);
        check("rst_busy",      busy,      0);
        check("rst_acc_ovf",   acc_ovf,   0);
        check("rst_drop_err",  drop_err,  0);
        check("rst_out_data",  out_data,  0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("credit_after_rst", issue_ok, 1);

        // Single beat: visible exactly LAT+1 cycles after issue
        drive(1'b1, 1'b1, 16'h0100, 1'b0);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check("t1_not_yet_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_valid_at_lat1", out_valid, 1);
        check("t1_busy_done", busy, 0);
        @(posedge clk); #1;
        ready_mode = 1;
        idle(3);

        // Four-beat group
        drive(1'b1, 1'b0, 16'sd1000, 1'b0);
        drive(1'b1, 1'b0, 16'sd2000, 1'b0);
        drive(1'b1, 1'b0, -16'sd500, 1'b0);
        drive(1'b1, 1'b1, 16'sd3,    1'b0);
        idle(LAT + 3);
        check("t2_busy_idle", busy, 0);
        check("t2_drained", exp_q.size(), 0);

        // Saturation both ways
        repeat (2) drive(1'b1, 1'b0, 16'h7000, 1'b0);
        drive(1'b1, 1'b1, 16'h7000, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 16'h9000, 1'b0);
        drive(1'b1, 1'b1, 16'h9000, 1'b0);
        idle(LAT + 3);
        check("t3_acc_ovf", acc_ovf, 0);
        check("t3_drained", exp_q.size(), 0);

        // Fill FIFO; over-issue a fifth group timed to meet a pop at push
        ready_mode = 0;
        idle(2);
        drive(1'b1, 1'b1, 16'sd11, 1'b0);
        drive(1'b1, 1'b1, 16'sd22, 1'b0);
        drive(1'b1, 1'b1, 16'sd33, 1'b0);
        drive(1'b1, 1'b1, 16'sd44, 1'b0);
        check("t4_credit_exhausted", issue_ok, 0);
        drive(1'b1, 1'b1, 16'sd55, 1'b0);
        repeat (LAT - 1) @(posedge clk);
        #1;
        ready_mode = 1;
        @(posedge clk); #1;
        ready_mode = 0;
        idle(3);
        check("t4_full_push_pop_no_drop", drop_err, 0);
        check("t4_full_again", issue_ok, 0);
        ready_mode = 1;
        idle(8);
        check("t4_drained", exp_q.size(), 0);

        // Fill again; a fifth close with no pop is discarded
        ready_mode = 0;
        idle(2);
        drive(1'b1, 1'b1, 16'sd101, 1'b0);
        drive(1'b1, 1'b1, 16'sd102, 1'b0);
        drive(1'b1, 1'b1, 16'sd103, 1'b0);
        drive(1'b1, 1'b1, 16'sd104, 1'b0);
        check("t4b_credit_exhausted", issue_ok, 0);
        drive(1'b1, 1'b1, 16'sd105, 1'b1);
        idle(LAT + 2);
        check("t4b_drop_err", drop_err, 1);
        check("t4b_fifo_holds", out_valid, 1);
        check("t4b_still_full", issue_ok, 0);
        ready_mode = 1;
        idle(8);
        check("t4b_drained", exp_q.size(), 0);
        check("t4b_credit_back", issue_ok, 1);

        // Back-to-back random groups against a toggling, then random, consumer
        for (int g = 0; g < 80; g++) begin
            ready_mode = (g < 40) ? 2 : 3;
            glen = $urandom_range(1, 5);
            for (int b = 0; b < glen - 1; b++) drive(1'b1, 1'b0, rnd_res(), 1'b0);
            spin = 0;
            while (!issue_ok && spin < 200) begin
                drive(1'b1, 1'b0, rnd_res(), 1'b0);
                spin++;
            end
            if (spin >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL t5_credit_timeout: got issue_ok %0d, expected 1", issue_ok);
            end
            drive(1'b1, 1'b1, rnd_res(), 1'b0);
        end
        ready_mode = 1;
        idle(LAT + 8);
        check("t5_drained", exp_q.size(), 0);
        check("t5_acc_ovf", acc_ovf, 0);

        // Soft flush with a queued result and two beats in flight
        ready_mode = 0;
        idle(2);
        drive(1'b1, 1'b1, 16'sd7, 1'b0);
        idle(LAT + 2);
        check("t6_queued", out_valid, 1);
        drive(1'b1, 1'b0, 16'sd100, 1'b0);
        drive(1'b1, 1'b0, 16'sd200, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_flush();
        @(negedge clk);
        check("t6_clr_out_valid", out_valid, 0);
        check("t6_clr_busy",      busy,      0);
        check("t6_clr_drop_kept", drop_err,  1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 16'sd5,  1'b0);
        drive(1'b1, 1'b1, -16'sd9, 1'b0);
        ready_mode = 1;
        idle(LAT + 3);
        check("t6_post_clr_drained", exp_q.size(), 0);

        // Hard reset mid-group clears everything, stickies included
        drive(1'b1, 1'b0, 16'sd50, 1'b0);
        drive(1'b1, 1'b0, 16'sd60, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        model_flush();
        @(negedge clk);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_busy",      busy,      0);
        check("t6_rst_drop_err",  drop_err,  0);
        check("t6_rst_acc_ovf",   acc_ovf,   0);
        check("t6_rst_issue_ok",  issue_ok,  0);
        check("t6_rst_out_cnt",   out_cnt,   0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, -16'sd3, 1'b0);

        spin = 0;
        while (exp_q.size() != 0 && spin < 100) begin
            idle(1);
            spin++;
        end
        check("final_drained", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
